run_pattern_gen: RTL and testbench



---
 rtl/run_pattern_gen_pkg.sv | 20 ++
 rtl/run_pattern_gen_if.sv | 12 +
 rtl/run_pattern_gen_run_len_model.sv | 40 ++++
 rtl/run_pattern_gen.sv | 104 ++++++++++
 tb/tb_run_pattern_gen.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/run_pattern_gen_pkg.sv
// Shared types and constants for the run pattern generator and its run-length model.
package run_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_RUN_DEFAULT = 3;

  // PRBS7 x^7 + x^6 + 1, Fibonacci form
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  // Shift left; the new LSB is the feedback bit and is also the emitted filler bit
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/run_pattern_gen_if.sv
// Command handshake bundle: (bit, length) run commands over valid/ready.
interface run_pattern_gen_if #(
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_bit;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_bit, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_bit, input cmd_len, output cmd_ready);
endinterface

// File: rtl/run_pattern_gen_run_len_model.sv
// Cycle-exact model of a registered consecutive-equal-bit run detector.
// y_o asserts once the trailing run of equal samples reaches MIN_RUN.
module run_len_model #(
  parameter int unsigned MIN_RUN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_i,
  output logic y_o
);
  localparam int unsigned CNT_W = $clog2(MIN_RUN + 1);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q;

  // Saturating run counter; a zero count (just after reset) starts a fresh run
  always_comb begin
    cnt_d = CNT_W'(1);
    if (cnt_q == '0 || bit_i == prev_q) begin
      cnt_d = (cnt_q == CNT_W'(MIN_RUN)) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Register previous bit, run count and the detector output
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else begin
      prev_q <= bit_i;
      cnt_q  <= cnt_d;
      y_q    <= (cnt_d >= CNT_W'(MIN_RUN));
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/run_pattern_gen.sv
// Serial run pattern generator: serialises (bit, length) commands onto x_out
// and predicts the run detector output on exp_y.
// Optional macro RUN_PATTERN_GEN_PRBS_IDLE_EN: idle filler comes from a PRBS7
// LFSR instead of holding the last bit.
module run_pattern_gen
  import run_pattern_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned MIN_RUN = MIN_RUN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  run_pattern_gen_if.slave  cmd,
  output logic              x_out,
  output logic              x_valid,
  output logic              busy,
  output logic              exp_y
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q;
  logic             accept;
  logic             load;

`ifdef RUN_PATTERN_GEN_PRBS_IDLE_EN
  logic [6:0] lfsr_q, lfsr_d;
`endif

  assign cmd.cmd_ready = (state_q == IDLE) || (rem_q == '0);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign load          = accept && (cmd.cmd_len != '0);

  // Next-state, remaining count and wire bit selection
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    x_d     = x_q;
    xv_d    = 1'b0;
`ifdef RUN_PATTERN_GEN_PRBS_IDLE_EN
    lfsr_d  = lfsr_q;
`endif
    if (state_q == RUN && rem_q != '0) begin
      rem_d = rem_q - LEN_W'(1);
      xv_d  = 1'b1;
    end else if (load) begin
      state_d = RUN;
      x_d     = cmd.cmd_bit;
      xv_d    = 1'b1;
      rem_d   = cmd.cmd_len - LEN_W'(1);
    end else begin
      // Run finished or nothing to do: emit filler. The edge leaving RUN
      // still holds the last bit; the LFSR only drives filler from IDLE.
      state_d = IDLE;
`ifdef RUN_PATTERN_GEN_PRBS_IDLE_EN
      if (state_q == IDLE) begin
        lfsr_d = prbs7_next(lfsr_q);
        x_d    = lfsr_d[0];
      end
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= (state_d == RUN);
    end
  end

`ifdef RUN_PATTERN_GEN_PRBS_IDLE_EN
  // Filler LFSR, reseeded on reset
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= PRBS7_SEED;
    else       lfsr_q <= lfsr_d;
  end
`endif

  assign x_out   = x_q;
  assign x_valid = xv_q;
  assign busy    = busy_q;

  run_len_model #(
    .MIN_RUN(MIN_RUN)
  ) u_model (
    .clk   (clk),
    .reset (reset),
    .bit_i (x_q),
    .y_o   (exp_y)
  );

endmodule

// File: tb/tb_run_pattern_gen.sv
// Self-checking bench for run_pattern_gen: a directed vector table followed by
// randomized commands compared against a queue-based behavioural model.
module tb_run_pattern_gen;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned MIN_RUN = 3;

  logic clk = 1'b0;
  logic reset;
  logic x_out, x_valid, busy, exp_y;

  always #5 clk = ~clk;

  run_pattern_gen_if #(.LEN_W(LEN_W)) cif ();

  run_pattern_gen #(
    .LEN_W   (LEN_W),
    .MIN_RUN (MIN_RUN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cif),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .exp_y   (exp_y)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: pending bits of the current run, wire history since reset
  bit       pend_q[$];
  bit       hist_q[$];
  bit       m_x, m_valid, m_busy, m_y;
  bit [6:0] m_lfsr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit hist_run_met();
    if (hist_q.size() < MIN_RUN) return 1'b0;
    foreach (hist_q[i]) if (hist_q[i] != hist_q[0]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, advance model on the edge, compare at negedge
  task automatic step(input bit rst, input bit v, input bit b, input int len);
    bit acc;
    bit sampled;
    reset         = rst;
    cif.cmd_valid = v;
    cif.cmd_bit   = b;
    cif.cmd_len   = LEN_W'(len);
    acc     = v && (pend_q.size() == 0);
    sampled = m_x;
    @(posedge clk);
    if (rst) begin
      pend_q.delete();
      hist_q.delete();
      m_x = 0; m_valid = 0; m_busy = 0; m_y = 0;
      m_lfsr = 7'h7F;
    end else begin
      hist_q.push_back(sampled);
      if (hist_q.size() > MIN_RUN) void'(hist_q.pop_front());
      m_y = hist_run_met();
      if (pend_q.size() != 0) begin
        m_x = pend_q.pop_front();
        m_valid = 1;
      end else if (acc && len > 0) begin
        m_x = b;
        for (int k = 1; k < len; k++) pend_q.push_back(b);
        m_valid = 1;
      end else begin
`ifdef RUN_PATTERN_GEN_PRBS_IDLE_EN
        if (!m_busy) begin
          m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
          m_x = m_lfsr[0];
        end
`endif
        m_valid = 0;
      end
      m_busy = m_valid;
    end
    @(negedge clk);
    chk("x_out",     int'(x_out),         int'(m_x));
    chk("x_valid",   int'(x_valid),       int'(m_valid));
    chk("busy",      int'(busy),          int'(m_busy));
    chk("cmd_ready", int'(cif.cmd_ready), int'(pend_q.size() == 0));
    chk("exp_y",     int'(exp_y),         int'(m_y));
  endtask

  typedef struct {
    bit rst, v, b;
    int len;
    bit x, xv, bsy, rdy, y;
  } vec_t;

  initial begin
    vec_t tbl[19];
    tbl = '{
      '{1,0,0,0, 0,0,0,1,0},  // reset
      '{0,1,0,3, 0,1,1,0,0},  // (0,3) first bit
      '{0,0,0,0, 0,1,1,0,0},
      '{0,0,0,0, 0,1,1,1,1},  // last bit, ready
      '{0,1,1,2, 1,1,1,0,1},  // back-to-back (1,2)
      '{0,0,0,0, 1,1,1,1,0},
      '{0,1,1,2, 1,1,1,0,0},  // merges with previous 1s
      '{0,0,0,0, 1,1,1,1,1},
      '{0,0,0,0, 1,0,0,1,1},  // idle, filler holds 1
      '{0,1,0,0, 1,0,0,1,1},  // len 0 in IDLE
      '{0,1,0,2, 0,1,1,0,1},
      '{0,1,1,5, 0,1,1,1,0},  // offered while not ready: ignored
      '{0,1,1,0, 0,0,0,1,0},  // len 0 at end of run
      '{0,0,0,0, 0,0,0,1,1},
      '{0,1,1,7, 1,1,1,0,1},  // (1,7)
      '{0,0,0,0, 1,1,1,0,0},  // 2nd bit on wire
      '{1,0,0,0, 0,0,0,1,0},  // reset aborts
      '{0,1,0,1, 0,1,1,1,0},  // single 0
      '{0,0,0,0, 0,0,0,1,0}
    };
    reset = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_bit   = 1'b0;
    cif.cmd_len   = '0;
    m_x = 0; m_valid = 0; m_busy = 0; m_y = 0; m_lfsr = 7'h7F;

    step(1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].len);
`ifndef RUN_PATTERN_GEN_PRBS_IDLE_EN
      chk("tbl_x_out",     int'(x_out),         int'(tbl[i].x));
      chk("tbl_x_valid",   int'(x_valid),       int'(tbl[i].xv));
      chk("tbl_busy",      int'(busy),          int'(tbl[i].bsy));
      chk("tbl_cmd_ready", int'(cif.cmd_ready), int'(tbl[i].rdy));
      chk("tbl_exp_y",     int'(exp_y),         int'(tbl[i].y));
`endif
    end

    // Idle stretch after reset (exercises PRBS filler when enabled)
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

    // Randomized command traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r, v, b;
      int len;
      r   = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 9) < 6);
      b   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, 3));
      step(r, v, b, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
